icsrc_arbiter: RTL and testbench

ICSRC_ARBITER -- requirements
Module: icsrc_arbiter

---
 rtl/icsrc_arbiter_pkg.sv | 32 +++
 rtl/arb_rr_pick.sv | 42 ++++
 rtl/icsrc_arbiter.sv | 114 +++++++++++
 tb/tb_icsrc_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icsrc_arbiter_pkg.sv
// Shared helpers for the interconnect source arbiter.
// Width fallbacks apply only when the shared constants are not already defined.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef CREDIT_WIDTH
`define CREDIT_WIDTH 8
`endif
`ifndef A_WIDTH
`define A_WIDTH 4
`endif

package icsrc_arbiter_pkg;

  // Bits needed to represent v (0 for v == 0).
  function automatic int clogb2(input int v);
    int r;
    int x;
    r = 0;
    x = v;
    while (x > 0) begin
      x = x >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int src_w(input int n);
    return (clogb2(n - 1) < 1) ? 1 : clogb2(n - 1);
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational masked round-robin picker.
// Requests above ptr win first; otherwise the lowest request wins.
module arb_rr_pick
  import icsrc_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] idx,
  output logic          any
);

  logic [N-1:0] mask;
  logic [N-1:0] hi;
  logic         hi_any;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i > int'(ptr));
    end
    hi     = req & mask;
    hi_any = |hi;
  end

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && (hi_any ? hi[i] : req[i])) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = SW'(i);
      end
    end
  end

endmodule

// File: rtl/icsrc_arbiter.sv
// Node-output arbiter feeding one registered interconnect slot.
// Optional ICSRC_STATS_EN builds saturating grant/stall counters.
module icsrc_arbiter
  import icsrc_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int WIDTH = `FLIT_WIDTH,
  parameter int AW    = `A_WIDTH,
  localparam int SW   = src_w(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [N-1:0]    in_valid,
  input  logic [N-1:0]    in_valid_urgent,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N*AW-1:0] in_nexthop,
  output logic [N-1:0]    in_dequeue,
  output logic            out_valid,
  output logic            out_urgent,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]   out_nexthop,
  output logic [SW-1:0]   out_src,
  input  logic            out_ack,
  output logic [15:0]     stats_grants,
  output logic [15:0]     stats_stalls
);

  logic [SW-1:0]    rr_ptr;
  logic [N-1:0]     urg_req;
  logic [N-1:0]     urg_gnt;
  logic [N-1:0]     all_gnt;
  logic [N-1:0]     win_gnt;
  logic [SW-1:0]    urg_idx;
  logic [SW-1:0]    all_idx;
  logic [SW-1:0]    win_idx;
  logic             urg_any;
  logic             all_any;
  logic             free;
  logic             grant;
  logic [WIDTH-1:0] win_data;
  logic [AW-1:0]    win_nh;

  assign urg_req = in_valid & in_valid_urgent;

  arb_rr_pick #(.N(N), .SW(SW)) u_urg (
    .req   (urg_req),
    .ptr   (rr_ptr),
    .grant (urg_gnt),
    .idx   (urg_idx),
    .any   (urg_any)
  );

  arb_rr_pick #(.N(N), .SW(SW)) u_all (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .grant (all_gnt),
    .idx   (all_idx),
    .any   (all_any)
  );

  assign free    = !out_valid || out_ack;
  assign grant   = enable && free && all_any && !reset;
  assign win_gnt = urg_any ? urg_gnt : all_gnt;
  assign win_idx = urg_any ? urg_idx : all_idx;

  assign in_dequeue = grant ? win_gnt : '0;

  always_comb begin
    win_data = in_data[int'(win_idx)*WIDTH +: WIDTH];
    win_nh   = in_nexthop[int'(win_idx)*AW +: AW];
  end

  // Slot loads on grant, drains when acked with nothing new to load.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_urgent  <= 1'b0;
      out_data    <= '0;
      out_nexthop <= '0;
      out_src     <= '0;
      rr_ptr      <= SW'(N - 1);
    end else if (grant) begin
      out_valid   <= 1'b1;
      out_urgent  <= urg_any;
      out_data    <= win_data;
      out_nexthop <= win_nh;
      out_src     <= win_idx;
      rr_ptr      <= win_idx;
    end else if (free) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef ICSRC_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stats_grants <= '0;
      stats_stalls <= '0;
    end else begin
      if (grant && stats_grants != 16'hFFFF) begin
        stats_grants <= stats_grants + 16'd1;
      end
      if (out_valid && !out_ack && stats_stalls != 16'hFFFF) begin
        stats_stalls <= stats_stalls + 16'd1;
      end
    end
  end
`else
  assign stats_grants = '0;
  assign stats_stalls = '0;
`endif

endmodule

// File: tb/tb_icsrc_arbiter.sv
// Directed scoreboard bench for icsrc_arbiter (N=4).
// Expected slot contents are queued at grant time and popped when the slot loads.
module tb_icsrc_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 4;

  logic           clock;
  logic           reset;
  logic           enable;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_valid_urgent;
  logic [N*W-1:0] in_data;
  logic [N*AW-1:0] in_nexthop;
  logic [N-1:0]   in_dequeue;
  logic           out_valid;
  logic           out_urgent;
  logic [W-1:0]   out_data;
  logic [AW-1:0]  out_nexthop;
  logic [1:0]     out_src;
  logic           out_ack;
  logic [15:0]    stats_grants;
  logic [15:0]    stats_stalls;

  icsrc_arbiter #(.N(N), .WIDTH(W), .AW(AW)) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .in_valid        (in_valid),
    .in_valid_urgent (in_valid_urgent),
    .in_data         (in_data),
    .in_nexthop      (in_nexthop),
    .in_dequeue      (in_dequeue),
    .out_valid       (out_valid),
    .out_urgent      (out_urgent),
    .out_data        (out_data),
    .out_nexthop     (out_nexthop),
    .out_src         (out_src),
    .out_ack         (out_ack),
    .stats_grants    (stats_grants),
    .stats_stalls    (stats_stalls)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [AW-1:0] nh;
    logic [1:0]    src;
    logic          urg;
  } slot_t;

  slot_t      sb[$];
  slot_t      cur;
  int         checks;
  int         errors;
  int         cyc;
  logic       m_valid;
  int         m_ptr;
  int         m_grants;
  int         m_stalls;
  logic [N-1:0] obs_deq;
  logic [3:0] seq [5];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) begin
      in_data[i*W +: W]     = 16'(16'hA000 + i * 256 + cyc);
      in_nexthop[i*AW +: AW] = 4'(i * 3 + cyc);
    end
  endtask

  // One clock: check the combinational pop, then the registered slot.
  task automatic cycle();
    logic [N-1:0] cls;
    logic         g;
    logic         fr;
    logic         stall;
    int           win;
    slot_t        e;
    drive_data();
    #1;
    cls = ((in_valid & in_valid_urgent) != 0) ?
          (in_valid & in_valid_urgent) : in_valid;
    fr  = !m_valid || out_ack;
    g   = enable && fr && (in_valid != 0) && !reset;
    win = 0;
    if (g) begin
      for (int k = N; k >= 1; k--) begin
        if (cls[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
    end
    stall   = m_valid && !out_ack;
    obs_deq = in_dequeue;
    chk("dequeue", 32'(in_dequeue), g ? (32'd1 << win) : 32'd0);
    if (g) begin
      e.data = in_data[win*W +: W];
      e.nh   = in_nexthop[win*AW +: AW];
      e.src  = 2'(win);
      e.urg  = ((in_valid & in_valid_urgent) != 0);
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    cyc++;
    if (reset) begin
      m_valid  = 1'b0;
      m_ptr    = N - 1;
      m_grants = 0;
      m_stalls = 0;
      sb.delete();
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_src", 32'(out_src), 32'd0);
      chk("rst_nh", 32'(out_nexthop), 32'd0);
      chk("rst_urg", 32'(out_urgent), 32'd0);
    end else begin
      if (stall && m_stalls < 65535) m_stalls++;
      if (g) begin
        m_valid = 1'b1;
        m_ptr   = win;
        if (m_grants < 65535) m_grants++;
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
        end
      end else if (fr) begin
        m_valid = 1'b0;
      end
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(cur.data));
      chk("out_nh", 32'(out_nexthop), 32'(cur.nh));
      chk("out_src", 32'(out_src), 32'(cur.src));
      chk("out_urg", 32'(out_urgent), 32'(cur.urg));
    end
`ifdef ICSRC_STATS_EN
    chk("st_grants", 32'(stats_grants), 32'(m_grants));
    chk("st_stalls", 32'(stats_stalls), 32'(m_stalls));
`else
    chk("st_grants", 32'(stats_grants), 32'd0);
    chk("st_stalls", 32'(stats_stalls), 32'd0);
`endif
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    cyc             = 0;
    m_valid         = 1'b0;
    m_ptr           = N - 1;
    m_grants        = 0;
    m_stalls        = 0;
    reset           = 1'b1;
    enable          = 1'b0;
    in_valid        = '0;
    in_valid_urgent = '0;
    out_ack         = 1'b0;
    in_data         = '0;
    in_nexthop      = '0;
    seq[0] = 4'b0001;
    seq[1] = 4'b0010;
    seq[2] = 4'b0100;
    seq[3] = 4'b1000;
    seq[4] = 4'b0001;
    #2;
    enable   = 1'b1;
    in_valid = 4'b1111;
    cycle();
    cycle();
    chk("rst_deq", 32'(obs_deq), 32'd0);

    // Steady requests with immediate ack: one transfer per cycle.
    reset   = 1'b0;
    out_ack = 1'b1;
    chk("t1_idle", 32'(out_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t1_seq", 32'(obs_deq), 32'(seq[i]));
      if (i == 0) chk("t1_lat", 32'(out_valid), 32'd1);
    end

    // Urgent class wins, then round-robin resumes after it.
    in_valid_urgent = 4'b0100;
    cycle();
    chk("t2_urg", 32'(obs_deq), 32'b0100);
    chk("t2_urg_bit", 32'(out_urgent), 32'd1);
    in_valid_urgent = 4'b0000;
    cycle();
    chk("t2_next", 32'(obs_deq), 32'b1000);
    chk("t2_urg_clr", 32'(out_urgent), 32'd0);

    // Backpressure: slot holds, nothing pops.
    out_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_nopop", 32'(obs_deq), 32'd0);
    end
`ifdef ICSRC_STATS_EN
    chk("t3_stalls", 32'(stats_stalls), 32'd5);
    chk("t3_grants", 32'(stats_grants), 32'd7);
`else
    chk("t3_stalls", 32'(stats_stalls), 32'd0);
`endif

    // Disabled: ack drains the slot, no grant until enable returns.
    enable  = 1'b0;
    out_ack = 1'b1;
    cycle();
    chk("t4_nopop", 32'(obs_deq), 32'd0);
    chk("t4_drain", 32'(out_valid), 32'd0);
    out_ack = 1'b0;
    cycle();
    chk("t4_idle", 32'(obs_deq), 32'd0);
    enable = 1'b1;
    cycle();
    chk("t4_grant", 32'(obs_deq), 32'b0001);

    // Dropped requests are skipped; wrap through N-1.
    out_ack  = 1'b1;
    in_valid = 4'b1010;
    cycle();
    chk("t5_skip", 32'(obs_deq), 32'b0010);
    in_valid = 4'b1001;
    cycle();
    chk("t5_wrap", 32'(obs_deq), 32'b1000);
    in_valid = 4'b0001;
    cycle();
    chk("t5_wrap0", 32'(obs_deq), 32'b0001);
    in_valid = 4'b0000;
    cycle();
    chk("t5_empty", 32'(out_valid), 32'd0);

    // Reset mid-transfer discards the slot.
    in_valid = 4'b1111;
    cycle();
    out_ack = 1'b0;
    reset   = 1'b1;
    cycle();
    chk("t6_rst_deq", 32'(obs_deq), 32'd0);
    chk("t6_rst_ov", 32'(out_valid), 32'd0);
    reset   = 1'b0;
    out_ack = 1'b1;
    cycle();
    chk("t6_first", 32'(obs_deq), 32'b0001);
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
